// File: rtl/match_pkg.sv
// Shared defaults for the 1011-detector match path: widths, depth and the
// FIFO level-width helper used by the RTL, the detector wrapper and benches.
package match_pkg;

    localparam int POS_W_DEF = 16;
    localparam int DEPTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    // Level must represent 0..depth inclusive, hence depth+1 states.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: head entry is visible on dout
// whenever the FIFO is non-empty. Async reset and sync clear empty it.
module sync_fifo_fwft
    import match_pkg::*;
#(
    parameter int DATA_W = POS_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LVL_W  = level_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == {LVL_W{1'b0}});
    assign dout  = mem[rd_ptr];

    // Qualify requests: a push into a full FIFO is legal only alongside a pop.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Storage; cleared so the head reads 0 while empty after reset/clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {DATA_W{1'b0}};
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {DATA_W{1'b0}};
            end
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Read/write pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= {PTR_W{1'b0}};
            rd_ptr <= {PTR_W{1'b0}};
        end else if (clear) begin
            wr_ptr <= {PTR_W{1'b0}};
            rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy counter covering 0..DEPTH; simultaneous push/pop holds it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= {LVL_W{1'b0}};
        end else if (clear) begin
            level <= {LVL_W{1'b0}};
        end else begin
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/match_event_fifo.sv
// Time-stamps each 1011-detector match with a free-running bit position and
// queues the stamps in a FWFT FIFO, with a saturating match count and overflow.
module match_event_fifo
    import match_pkg::*;
#(
    parameter int POS_W = POS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          match_in,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [POS_W-1:0]              pos_out,
    output logic [level_width(DEPTH)-1:0] fifo_level,
    output logic [CNT_W-1:0]              match_count,
    output logic                          overflow
);

    localparam int LVL_W = level_width(DEPTH);

    logic [POS_W-1:0] pos;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push;
    logic             drop;

    assign evt_valid = !fifo_empty;

    // A full FIFO still accepts a match when the consumer frees a slot this cycle.
    always_comb begin
        pop  = evt_valid && evt_ready;
        push = match_in && (!fifo_full || pop);
        drop = match_in && fifo_full && !pop;
    end

    sync_fifo_fwft #(
        .DATA_W (POS_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (pos),
        .dout  (pos_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Free-running bit-position counter, wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos <= {POS_W{1'b0}};
        end else if (clear) begin
            pos <= {POS_W{1'b0}};
        end else begin
            pos <= pos + POS_W'(1);
        end
    end

    // Match counter saturates at all-ones; counts dropped matches too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_count <= {CNT_W{1'b0}};
        end else if (clear) begin
            match_count <= {CNT_W{1'b0}};
        end else if (match_in && (match_count != {CNT_W{1'b1}})) begin
            match_count <= match_count + CNT_W'(1);
        end else begin
            match_count <= match_count;
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else begin
            overflow <= overflow;
        end
    end

endmodule

// File: tb/tb_match_event_fifo.sv
// Bench for match_event_fifo: a default-width instance and a 4-bit pos/count
// instance share stimulus and are compared against a queue-based model.
module tb_match_event_fifo;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    logic clear;
    logic match_in;
    logic evt_ready;

    logic        ev_a;
    logic [15:0] pos_a;
    logic [3:0]  lvl_a;
    logic [15:0] cnt_a;
    logic        ovf_a;

    logic        ev_b;
    logic [3:0]  pos_b;
    logic [3:0]  lvl_b;
    logic [3:0]  cnt_b;
    logic        ovf_b;

    int mq[$];
    int mpos;
    int mcnt;
    bit movf;
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    match_event_fifo dut_a (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .match_in    (match_in),
        .evt_valid   (ev_a),
        .evt_ready   (evt_ready),
        .pos_out     (pos_a),
        .fifo_level  (lvl_a),
        .match_count (cnt_a),
        .overflow    (ovf_a)
    );

    match_event_fifo #(.POS_W(4), .DEPTH(8), .CNT_W(4)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .match_in    (match_in),
        .evt_valid   (ev_b),
        .evt_ready   (evt_ready),
        .pos_out     (pos_b),
        .fifo_level  (lvl_b),
        .match_count (cnt_b),
        .overflow    (ovf_b)
    );

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        mq.delete();
        mpos = 0;
        mcnt = 0;
        movf = 1'b0;
    endtask

    // One clock: drive inputs, advance the model at the edge, settle 1 time unit.
    task automatic cycle(input bit c, input bit m, input bit r);
        bit do_pop;
        clear     = c;
        match_in  = m;
        evt_ready = r;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            do_pop = r && (mq.size() > 0);
            if (m) mcnt++;
            if (do_pop) void'(mq.pop_front());
            if (m) begin
                if (mq.size() < DEPTH) mq.push_back(mpos);
                else movf = 1'b1;
            end
            mpos++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; match_in = 1'b0; evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ev_a !== 1'b0)  $display("FAIL reset_valid: got %0d expected 0", ev_a);  else passed++;
        total++; if (lvl_a !== 4'd0) $display("FAIL reset_level: got %0d expected 0", lvl_a); else passed++;
        total++; if (cnt_a !== 16'd0) $display("FAIL reset_count: got %0d expected 0", cnt_a); else passed++;
        total++; if (ovf_a !== 1'b0) $display("FAIL reset_ovf: got %0d expected 0", ovf_a);  else passed++;
        total++; if (pos_a !== 16'd0) $display("FAIL reset_pos: got %0d expected 0", pos_a);  else passed++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_capture();
        repeat (5) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        total++; if (lvl_a !== 4'd2)  $display("FAIL basic_level: got %0d expected 2", lvl_a); else passed++;
        total++; if (cnt_a !== 16'd2) $display("FAIL basic_count: got %0d expected 2", cnt_a); else passed++;
        total++; if (pos_a !== 16'd5) $display("FAIL basic_head0: got %0d expected 5", pos_a); else passed++;
        cycle(1'b0, 1'b0, 1'b1);
        total++; if (pos_a !== 16'd9) $display("FAIL basic_head1: got %0d expected 9", pos_a); else passed++;
        total++; if (ev_a !== 1'b1)   $display("FAIL basic_valid1: got %0d expected 1", ev_a); else passed++;
        cycle(1'b0, 1'b0, 1'b1);
        total++; if (ev_a !== 1'b0)   $display("FAIL basic_drained: got %0d expected 0", ev_a); else passed++;
    endtask

    task automatic test_overflow();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        repeat (9) cycle(1'b0, 1'b1, 1'b0);
        total++; if (lvl_a !== 4'd8)   $display("FAIL ovf_level: got %0d expected 8", lvl_a);  else passed++;
        total++; if (cnt_a !== 16'd9)  $display("FAIL ovf_count: got %0d expected 9", cnt_a);  else passed++;
        total++; if (ovf_a !== 1'b1)   $display("FAIL ovf_flag: got %0d expected 1", ovf_a);   else passed++;
        total++; if (pos_a !== 16'd10) $display("FAIL ovf_head: got %0d expected 10", pos_a);  else passed++;
        total++; if (pos_b !== 4'd10)  $display("FAIL ovf_head_b: got %0d expected 10", pos_b); else passed++;
        total++; if (ovf_b !== 1'b1)   $display("FAIL ovf_flag_b: got %0d expected 1", ovf_b); else passed++;
    endtask

    task automatic test_full_push_pop();
        int exp_pos;
        cycle(1'b1, 1'b0, 1'b0);
        repeat (8) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        total++; if (lvl_a !== 4'd8)  $display("FAIL fullpp_level: got %0d expected 8", lvl_a); else passed++;
        total++; if (ovf_a !== 1'b0)  $display("FAIL fullpp_ovf: got %0d expected 0", ovf_a);   else passed++;
        total++; if (pos_a !== 16'd1) $display("FAIL fullpp_head: got %0d expected 1", pos_a);  else passed++;
        for (int i = 1; i <= 8; i++) begin
            exp_pos = i;
            total++;
            if (!ev_a || pos_a !== 16'(exp_pos))
                $display("FAIL fullpp_drain%0d: got %0d valid %0d expected %0d", i, pos_a, ev_a, exp_pos);
            else passed++;
            cycle(1'b0, 1'b0, 1'b1);
        end
        total++; if (ev_a !== 1'b0) $display("FAIL fullpp_empty: got %0d expected 0", ev_a); else passed++;
    endtask

    task automatic test_wrap_saturation();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (17) cycle(1'b0, 1'b1, 1'b1);
        total++; if (cnt_b !== 4'd15)  $display("FAIL sat_count_b: got %0d expected 15", cnt_b); else passed++;
        total++; if (cnt_a !== 16'd17) $display("FAIL sat_count_a: got %0d expected 17", cnt_a); else passed++;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        total++; if (pos_b !== 4'd2)   $display("FAIL wrap_pos_b: got %0d expected 2", pos_b);   else passed++;
        total++; if (pos_a !== 16'd18) $display("FAIL wrap_pos_a: got %0d expected 18", pos_a);  else passed++;
    endtask

    task automatic test_clear_priority();
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        total++; if (lvl_a !== 4'd0)  $display("FAIL clr_level: got %0d expected 0", lvl_a); else passed++;
        total++; if (cnt_a !== 16'd0) $display("FAIL clr_count: got %0d expected 0", cnt_a); else passed++;
        total++; if (ovf_a !== 1'b0)  $display("FAIL clr_ovf: got %0d expected 0", ovf_a);   else passed++;
        total++; if (ev_a !== 1'b0)   $display("FAIL clr_valid: got %0d expected 0", ev_a);  else passed++;
        cycle(1'b0, 1'b1, 1'b0);
        total++; if (pos_a !== 16'd0) $display("FAIL clr_poscnt: got %0d expected 0", pos_a); else passed++;
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (12) cycle(1'b0, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        total++; if (lvl_a !== 4'd3) $display("FAIL arst_pre_level: got %0d expected 3", lvl_a); else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++; if (ev_a !== 1'b0)   $display("FAIL arst_valid: got %0d expected 0", ev_a);  else passed++;
        total++; if (lvl_a !== 4'd0)  $display("FAIL arst_level: got %0d expected 0", lvl_a); else passed++;
        total++; if (cnt_a !== 16'd0) $display("FAIL arst_count: got %0d expected 0", cnt_a); else passed++;
        total++; if (ovf_a !== 1'b0)  $display("FAIL arst_ovf: got %0d expected 0", ovf_a);   else passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        bit c, m, r;
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 59) == 0);
            m = $urandom_range(0, 1) == 1;
            r = ($urandom_range(0, 3) < (i / 100));
            cycle(c, m, r);
            total++; if (lvl_a !== 4'(mq.size())) $display("FAIL rnd_level_a: got %0d expected %0d", lvl_a, mq.size()); else passed++;
            total++; if (ev_a !== (mq.size() != 0)) $display("FAIL rnd_valid_a: got %0d expected %0d", ev_a, mq.size() != 0); else passed++;
            total++; if (cnt_a !== 16'(sat(mcnt, 65535))) $display("FAIL rnd_count_a: got %0d expected %0d", cnt_a, sat(mcnt, 65535)); else passed++;
            total++; if (cnt_b !== 4'(sat(mcnt, 15))) $display("FAIL rnd_count_b: got %0d expected %0d", cnt_b, sat(mcnt, 15)); else passed++;
            total++; if (ovf_a !== movf || ovf_b !== movf) $display("FAIL rnd_ovf: got %0d/%0d expected %0d", ovf_a, ovf_b, movf); else passed++;
            if (mq.size() != 0) begin
                total++; if (pos_a !== 16'(mq[0])) $display("FAIL rnd_pos_a: got %0d expected %0d", pos_a, 16'(mq[0])); else passed++;
                total++; if (pos_b !== 4'(mq[0])) $display("FAIL rnd_pos_b: got %0d expected %0d", pos_b, 4'(mq[0])); else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_overflow();
        test_full_push_pop();
        test_wrap_saturation();
        test_clear_priority();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
